// File: rtl/stack_exec_unit_pkg.sv
// Shared definitions for the stack CPU operand-stack execution engine:
// opcodes, FSM states, error codes and small decode helpers.
package stack_exec_unit_pkg;

  localparam int OPCODE_W = 5;

  typedef enum logic [OPCODE_W-1:0] {
    OP_PUSH_IMM = 5'b00000,
    OP_ADD      = 5'b00001,
    OP_SUB      = 5'b00010,
    OP_MUL      = 5'b00011,
    OP_DIV      = 5'b00100,
    OP_MOD      = 5'b00101,
    OP_AND      = 5'b00110,
    OP_OR       = 5'b00111,
    OP_INVERT   = 5'b01000,
    OP_DUP      = 5'b01001,
    OP_SWAP     = 5'b01010,
    OP_DROP     = 5'b01011,
    OP_HALT     = 5'b11111
  } opcode_t;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_POP2,
    S_POP1,
    S_PUSH,
    S_PUSH2,
    S_HALTED,
    S_ERROR
  } state_t;

  typedef enum logic [2:0] {
    ERR_NONE      = 3'b000,
    ERR_UNDERFLOW = 3'b001,
    ERR_OVERFLOW  = 3'b010,
    ERR_DIV0      = 3'b011,
    ERR_ILLEGAL   = 3'b100
  } err_t;

  function automatic logic is_legal(input logic [OPCODE_W-1:0] code);
    return (code <= 5'b01011) || (code == 5'b11111);
  endfunction

  function automatic logic [1:0] operands_needed(input opcode_t op);
    case (op)
      OP_PUSH_IMM, OP_HALT:         return 2'd0;
      OP_INVERT, OP_DUP, OP_DROP:   return 2'd1;
      default:                      return 2'd2;
    endcase
  endfunction

endpackage

// File: rtl/stack_exec_unit_alu.sv
// Combinational ALU for the stack engine: result = A op B (INVERT uses B only).
module stack_alu
  import stack_exec_unit_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [OPCODE_W-1:0]   op,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [DATA_WIDTH-1:0] result
);

  always_comb begin
    result = '0;
    case (opcode_t'(op))
      OP_ADD:    result = a + b;
      OP_SUB:    result = a - b;
      OP_MUL:    result = a * b;
      // zero divisor never reaches here legally; force a defined value anyway
      OP_DIV:    result = (b == '0) ? '0 : a / b;
      OP_MOD:    result = (b == '0) ? '0 : a % b;
      OP_AND:    result = a & b;
      OP_OR:     result = a | b;
      OP_INVERT: result = ~b;
      default:   result = '0;
    endcase
  end

endmodule

// File: rtl/stack_exec_unit.sv
// Operand-stack execution engine: accepts instructions over valid/ready and
// executes them with a multi-cycle FSM, with sticky halt and error status.
module stack_exec_unit
  import stack_exec_unit_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int STACK_DEPTH = 16,
  parameter int INSTR_WIDTH = 16,
  parameter int IMM_WIDTH   = INSTR_WIDTH - 5,
  parameter int DEPTH_W     = $clog2(STACK_DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [INSTR_WIDTH-1:0] instr_i,
  input  logic                   instr_valid,
  output logic                   instr_ready,
  output logic                   instr_done,
  output logic [DATA_WIDTH-1:0]  tos,
  output logic [DEPTH_W-1:0]     depth,
  output logic                   busy,
  output logic                   halted,
  output logic                   error,
  output logic [2:0]             err_code
);

  localparam int PTR_W = $clog2(STACK_DEPTH);

  logic [DATA_WIDTH-1:0]  stack [STACK_DEPTH];
  logic [DEPTH_W-1:0]     depth_q;
  state_t                 state;
  err_t                   err_q, dec_err;
  logic [INSTR_WIDTH-1:0] instr_q;
  logic [DATA_WIDTH-1:0]  opa, opb, alu_res, imm_ext;
  logic [PTR_W-1:0]       top_idx, nos_idx, push_idx;
  logic [OPCODE_W-1:0]    op_bits;
  logic [IMM_WIDTH-1:0]   imm;
  opcode_t                op;

  assign op_bits  = instr_q[INSTR_WIDTH-1 -: OPCODE_W];
  assign op       = opcode_t'(op_bits);
  assign imm      = instr_q[IMM_WIDTH-1:0];
  assign imm_ext  = DATA_WIDTH'($signed(imm));
  assign top_idx  = PTR_W'(depth_q - DEPTH_W'(1));
  assign nos_idx  = PTR_W'(depth_q - DEPTH_W'(2));
  assign push_idx = PTR_W'(depth_q);

  stack_alu #(.DATA_WIDTH(DATA_WIDTH)) u_alu (
    .op     (op_bits),
    .a      (opa),
    .b      (opb),
    .result (alu_res)
  );

  // All checks resolve in DECODE so a faulting instruction never touches the stack.
  always_comb begin
    dec_err = ERR_NONE;
    if (!is_legal(op_bits))
      dec_err = ERR_ILLEGAL;
    else if (depth_q < DEPTH_W'(operands_needed(op)))
      dec_err = ERR_UNDERFLOW;
    else if ((op == OP_PUSH_IMM || op == OP_DUP) && depth_q == DEPTH_W'(STACK_DEPTH))
      dec_err = ERR_OVERFLOW;
    else if ((op == OP_DIV || op == OP_MOD) && stack[top_idx] == '0)
      dec_err = ERR_DIV0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_FETCH;
      depth_q    <= '0;
      err_q      <= ERR_NONE;
      instr_done <= 1'b0;
      instr_q    <= '0;
      opa        <= '0;
      opb        <= '0;
    end else begin
      instr_done <= 1'b0;
      case (state)
        S_FETCH: begin
          if (instr_valid) begin
            instr_q <= instr_i;
            state   <= S_DECODE;
          end
        end
        S_DECODE: begin
          if (dec_err != ERR_NONE) begin
            err_q <= dec_err;
            state <= S_ERROR;
          end else begin
            case (op)
              OP_PUSH_IMM, OP_DUP: begin
                state      <= S_PUSH;
                instr_done <= 1'b1;
              end
              OP_DROP: begin
                state      <= S_POP1;
                instr_done <= 1'b1;
              end
              OP_INVERT: state <= S_POP1;
              OP_HALT:   state <= S_HALTED;
              default:   state <= S_POP2;
            endcase
          end
        end
        S_POP2: begin
          opa   <= stack[nos_idx];
          state <= S_POP1;
        end
        S_POP1: begin
          if (op == OP_DROP) begin
            depth_q <= depth_q - DEPTH_W'(1);
            state   <= S_FETCH;
          end else begin
            opb        <= stack[top_idx];
            state      <= S_PUSH;
            instr_done <= (op != OP_SWAP);
          end
        end
        S_PUSH: begin
          state <= S_FETCH;
          case (op)
            OP_PUSH_IMM: begin
              stack[push_idx] <= imm_ext;
              depth_q         <= depth_q + DEPTH_W'(1);
            end
            OP_DUP: begin
              stack[push_idx] <= stack[top_idx];
              depth_q         <= depth_q + DEPTH_W'(1);
            end
            OP_INVERT: stack[top_idx] <= alu_res;
            OP_SWAP: begin
              stack[nos_idx] <= opb;
              state          <= S_PUSH2;
              instr_done     <= 1'b1;
            end
            default: begin
              stack[nos_idx] <= alu_res;
              depth_q        <= depth_q - DEPTH_W'(1);
            end
          endcase
        end
        S_PUSH2: begin
          stack[top_idx] <= opa;
          state          <= S_FETCH;
        end
        default: state <= state;
      endcase
    end
  end

  assign instr_ready = (state == S_FETCH);
  assign busy        = !(state == S_FETCH || state == S_HALTED || state == S_ERROR);
  assign halted      = (state == S_HALTED);
  assign error       = (state == S_ERROR);
  assign err_code    = err_q;
  assign depth       = depth_q;
  assign tos         = (depth_q == '0) ? '0 : stack[top_idx];

endmodule

// File: tb/tb_stack_exec_unit.sv
// Directed self-checking bench for stack_exec_unit with hand-computed expectations.
module tb_stack_exec_unit;

  localparam logic [4:0] PUSH = 5'b00000, ADD = 5'b00001, SUB = 5'b00010, MUL = 5'b00011,
                         DIV = 5'b00100, MOD = 5'b00101, INV = 5'b01000, DUP = 5'b01001,
                         SWAP = 5'b01010, DROP = 5'b01011, HALT = 5'b11111, BAD = 5'b10000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] instr_i = '0;
  logic        instr_valid = 1'b0;
  logic        instr_ready, instr_done, busy, halted, error;
  logic [31:0] tos;
  logic [4:0]  depth;
  logic [2:0]  err_code;

  int n_total = 0;
  int n_pass  = 0;
  int cyc;

  stack_exec_unit #(
    .DATA_WIDTH  (32),
    .STACK_DEPTH (16),
    .INSTR_WIDTH (16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .instr_i     (instr_i),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr_done  (instr_done),
    .tos         (tos),
    .depth       (depth),
    .busy        (busy),
    .halted      (halted),
    .error       (error),
    .err_code    (err_code)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] ins(input logic [4:0] o, input logic [10:0] imm);
    return {o, imm};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    instr_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Issues one instruction; cyc = FETCH-to-final-state cycle count, 0 if no instr_done.
  task automatic exec(input logic [15:0] word, output int cycles);
    int n;
    cycles = 0;
    n = 0;
    while (!instr_ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (!instr_ready) begin
      check("ready_timeout", {63'd0, instr_ready}, 64'd1);
      return;
    end
    instr_i = word;
    instr_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    instr_valid = 1'b0;
    n = 1;
    while (!instr_done && n < 8 && !error && !halted) begin
      @(negedge clk);
      n++;
    end
    if (instr_done) begin
      cycles = n + 1;
      @(negedge clk);
    end
  endtask

  initial begin
    // Reset state
    do_reset();
    check("rst_depth", depth, 0);
    check("rst_tos", tos, 0);
    check("rst_ready", instr_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_status", {halted, error, err_code}, 0);

    // 1: PUSH 5, PUSH 3, SUB
    exec(ins(PUSH, 11'd5), cyc); check("t1_push_cyc", cyc, 3);
    exec(ins(PUSH, 11'd3), cyc); check("t1_push2_cyc", cyc, 3);
    exec(ins(SUB, 11'd0), cyc);  check("t1_sub_cyc", cyc, 5);
    check("t1_tos", tos, 2);
    check("t1_depth", depth, 1);

    // 2: sign-extended all-ones, INVERT, DUP, MUL
    do_reset();
    exec(ins(PUSH, 11'h7FF), cyc);
    check("t2_push_tos", tos, 32'hFFFF_FFFF);
    exec(ins(INV, 11'd0), cyc); check("t2_inv_cyc", cyc, 4);
    check("t2_inv_tos", tos, 0);
    exec(ins(DUP, 11'd0), cyc); check("t2_dup_cyc", cyc, 3);
    check("t2_dup_depth", depth, 2);
    exec(ins(MUL, 11'd0), cyc);
    check("t2_mul_tos", tos, 0);
    check("t2_mul_depth", depth, 1);

    // 3: SWAP then SUB, DROP
    do_reset();
    exec(ins(PUSH, 11'd7), cyc);
    exec(ins(PUSH, 11'd9), cyc);
    exec(ins(SWAP, 11'd0), cyc); check("t3_swap_cyc", cyc, 6);
    check("t3_swap_tos", tos, 7);
    check("t3_swap_depth", depth, 2);
    exec(ins(SUB, 11'd0), cyc);
    check("t3_sub_tos", tos, 2);
    exec(ins(DROP, 11'd0), cyc); check("t3_drop_cyc", cyc, 3);
    check("t3_drop_depth", depth, 0);
    check("t3_drop_tos", tos, 0);

    // 4: fill to 16, binary op at full stack, refill, overflow
    do_reset();
    for (int i = 1; i <= 16; i++) exec(ins(PUSH, 11'(i)), cyc);
    check("t4_full_depth", depth, 16);
    check("t4_full_err", error, 0);
    check("t4_full_tos", tos, 16);
    exec(ins(ADD, 11'd0), cyc);
    check("t4_add_full_tos", tos, 31);
    check("t4_add_full_depth", depth, 15);
    exec(ins(PUSH, 11'd1), cyc);
    check("t4_refill_depth", depth, 16);
    check("t4_refill_err", error, 0);
    exec(ins(PUSH, 11'd2), cyc);
    check("t4_ovf_done", cyc, 0);
    check("t4_ovf_error", error, 1);
    check("t4_ovf_code", err_code, 3'b010);
    check("t4_ovf_depth", depth, 16);
    check("t4_ovf_tos", tos, 1);
    check("t4_ovf_ready", instr_ready, 0);

    // 5: underflow, normal DIV/MOD, underflow beats div0, div0
    do_reset();
    exec(ins(PUSH, 11'd1), cyc);
    exec(ins(ADD, 11'd0), cyc);
    check("t5_unf_code", err_code, 3'b001);
    check("t5_unf_depth", depth, 1);
    do_reset();
    exec(ins(PUSH, 11'd100), cyc);
    exec(ins(PUSH, 11'd7), cyc);
    exec(ins(DIV, 11'd0), cyc); check("t5_div_cyc", cyc, 5);
    check("t5_div_tos", tos, 14);
    exec(ins(PUSH, 11'd9), cyc);
    exec(ins(MOD, 11'd0), cyc);
    check("t5_mod_tos", tos, 5);
    do_reset();
    exec(ins(PUSH, 11'd0), cyc);
    exec(ins(DIV, 11'd0), cyc);
    check("t5_unf_over_div0", err_code, 3'b001);
    do_reset();
    exec(ins(PUSH, 11'd4), cyc);
    exec(ins(PUSH, 11'd0), cyc);
    exec(ins(MOD, 11'd0), cyc);
    check("t5_div0_code", err_code, 3'b011);
    check("t5_div0_tos", tos, 0);
    check("t5_div0_depth", depth, 2);

    // 6: illegal at depth 0 (beats underflow), HALT, reset mid-ADD
    do_reset();
    exec(ins(BAD, 11'd0), cyc);
    check("t6_ill_code", err_code, 3'b100);
    check("t6_ill_ready", instr_ready, 0);
    do_reset();
    check("t6_rst_clears_err", {error, err_code}, 0);
    exec(ins(PUSH, 11'd1), cyc);
    exec(ins(HALT, 11'd0), cyc);
    check("t6_halted", halted, 1);
    check("t6_halt_ready", instr_ready, 0);
    check("t6_halt_err", error, 0);
    check("t6_halt_depth", depth, 1);
    do_reset();
    exec(ins(PUSH, 11'd1), cyc);
    exec(ins(PUSH, 11'd2), cyc);
    instr_i = ins(ADD, 11'd0);
    instr_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    check("t6_midadd_busy", busy, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("t6_midrst_depth", depth, 0);
    check("t6_midrst_ready", instr_ready, 1);
    check("t6_midrst_tos", tos, 0);
    exec(ins(PUSH, 11'd6), cyc);
    check("t6_after_rst_tos", tos, 6);
    check("t6_after_rst_depth", depth, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
